// File: rtl/core_de_pipe_reg.sv
// ID->DE pipeline register with flush/stall/bubble priority; optional perf counters under CORE_DE_PERF_EN.
// Latency: id_* to de_* is one cycle on load; id_hold is combinational from the hazard inputs.
// Backpressure: ex_stall freezes DE and raises id_hold; insert_nop injects a bubble and raises id_hold.
module core_de_pipe_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_alu_op,
  input  logic [2:0]  id_funct3,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        insert_nop,
  input  logic        ex_flush,
  input  logic        ex_stall,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [31:0] de_rs1_data,
  output logic [31:0] de_rs2_data,
  output logic [31:0] de_imm,
  output logic [4:0]  de_rs1,
  output logic [4:0]  de_rs2,
  output logic [4:0]  de_rd,
  output logic [3:0]  de_alu_op,
  output logic [2:0]  de_funct3,
  output logic        de_reg_write,
  output logic        de_mem_read,
  output logic        de_mem_write,
  output logic        id_hold
`ifdef CORE_DE_PERF_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic do_flush;
  logic do_stall;
  logic do_bubble;
  logic do_load;

  // Exactly one action per cycle: flush beats stall beats bubble beats load.
  always_comb begin
    do_flush  = ex_flush;
    do_stall  = !ex_flush && ex_stall;
    do_bubble = !ex_flush && !ex_stall && insert_nop;
    do_load   = !ex_flush && !ex_stall && !insert_nop;
    id_hold   = !ex_flush && (ex_stall || insert_nop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_valid     <= 1'b0;
      de_pc        <= '0;
      de_rs1_data  <= '0;
      de_rs2_data  <= '0;
      de_imm       <= '0;
      de_rs1       <= '0;
      de_rs2       <= '0;
      de_rd        <= '0;
      de_alu_op    <= '0;
      de_funct3    <= '0;
      de_reg_write <= 1'b0;
      de_mem_read  <= 1'b0;
      de_mem_write <= 1'b0;
    end else if (do_flush || do_bubble) begin
      // Killing the slot only needs the side-effect bits; datapath fields are don't-care.
      de_valid     <= 1'b0;
      de_reg_write <= 1'b0;
      de_mem_read  <= 1'b0;
      de_mem_write <= 1'b0;
    end else if (do_load) begin
      de_valid     <= id_valid;
      de_pc        <= id_pc;
      de_rs1_data  <= id_rs1_data;
      de_rs2_data  <= id_rs2_data;
      de_imm       <= id_imm;
      de_rs1       <= id_rs1;
      de_rs2       <= id_rs2;
      de_rd        <= id_rd;
      de_alu_op    <= id_alu_op;
      de_funct3    <= id_funct3;
      // x0 writes are architecturally dead, so never advertise them to forwarding.
      de_reg_write <= id_valid && id_reg_write && (id_rd != 5'd0);
      de_mem_read  <= id_valid && id_mem_read;
      de_mem_write <= id_valid && id_mem_write;
    end
  end

`ifdef CORE_DE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (do_bubble) bubble_cnt <= bubble_cnt + 32'd1;
      if (do_flush)  flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_de_pipe_reg.sv
// Self-checking bench for core_de_pipe_reg: directed vector table plus randomized run against a rule-level model.
module tb_core_de_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } slot_t;

  typedef struct packed {
    logic        rst_n;
    logic        flush;
    logic        stall;
    logic        nop;
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        exp_hold;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [4:0]  exp_rd;
    logic        exp_rw;
    logic        exp_mr;
    logic        exp_mw;
    logic [31:0] exp_bub;
    logic [31:0] exp_fl;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n, insert_nop, ex_flush, ex_stall, id_hold;
  slot_t id;
  slot_t de;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

`ifdef CORE_DE_PERF_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  core_de_pipe_reg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id.valid),
    .id_pc        (id.pc),
    .id_rs1_data  (id.rs1_data),
    .id_rs2_data  (id.rs2_data),
    .id_imm       (id.imm),
    .id_rs1       (id.rs1),
    .id_rs2       (id.rs2),
    .id_rd        (id.rd),
    .id_alu_op    (id.alu_op),
    .id_funct3    (id.funct3),
    .id_reg_write (id.reg_write),
    .id_mem_read  (id.mem_read),
    .id_mem_write (id.mem_write),
    .insert_nop   (insert_nop),
    .ex_flush     (ex_flush),
    .ex_stall     (ex_stall),
    .de_valid     (de.valid),
    .de_pc        (de.pc),
    .de_rs1_data  (de.rs1_data),
    .de_rs2_data  (de.rs2_data),
    .de_imm       (de.imm),
    .de_rs1       (de.rs1),
    .de_rs2       (de.rs2),
    .de_rd        (de.rd),
    .de_alu_op    (de.alu_op),
    .de_funct3    (de.funct3),
    .de_reg_write (de.reg_write),
    .de_mem_read  (de.mem_read),
    .de_mem_write (de.mem_write),
    .id_hold      (id_hold)
`ifdef CORE_DE_PERF_EN
    ,
    .bubble_cnt   (bubble_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic chk_slot(input int idx, input slot_t act, input slot_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL de_slot [%0d]: got %h expected %h", idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic s, input logic n,
                              input logic v, input logic [31:0] pc, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw, input logic eh,
                              input logic ev, input logic [31:0] epc, input logic [4:0] erd,
                              input logic erw, input logic emr, input logic emw,
                              input logic [31:0] eb, input logic [31:0] ef);
    vec_t t;
    t = '{r, f, s, n, v, pc, rd, rw, mr, mw, eh, ev, epc, erd, erw, emr, emw, eb, ef};
    return t;
  endfunction

  vec_t vecs[16];

  // Behavioural reference: the expected DE slot follows directly from the action rules.
  slot_t       m_de;
  logic [31:0] m_bub, m_fl;

  task automatic model_step(input logic r, input logic f, input logic s, input logic n, input slot_t in);
    if (!r) begin
      m_de = '0; m_bub = 0; m_fl = 0;
    end else if (f) begin
      m_de.valid = 0; m_de.reg_write = 0; m_de.mem_read = 0; m_de.mem_write = 0;
      m_fl = m_fl + 1;
    end else if (s) begin
      m_de = m_de;
    end else if (n) begin
      m_de.valid = 0; m_de.reg_write = 0; m_de.mem_read = 0; m_de.mem_write = 0;
      m_bub = m_bub + 1;
    end else begin
      m_de = in;
      m_de.reg_write = in.valid & in.reg_write & (in.rd != 0);
      m_de.mem_read  = in.valid & in.mem_read;
      m_de.mem_write = in.valid & in.mem_write;
    end
  endtask

  initial begin
    logic [191:0] rbits;
    rst_n = 1'b0; insert_nop = 1'b0; ex_flush = 1'b0; ex_stall = 1'b0; id = '0;

    //          r f s n  v  pc       rd rw mr mw  hold v  pc       rd rw mr mw bub fl
    vecs[0]  = mk(0,0,0,0, 0, 32'h0,   0, 0,0,0,  0,  0, 32'h0,   0, 0,0,0, 0, 0);
    vecs[1]  = mk(1,0,0,0, 1, 32'h100, 5, 1,1,0,  0,  1, 32'h100, 5, 1,1,0, 0, 0);
    vecs[2]  = mk(1,0,0,1, 1, 32'h104, 6, 1,0,0,  1,  0, 32'h100, 5, 0,0,0, 1, 0);
    vecs[3]  = mk(1,0,0,0, 1, 32'h104, 6, 1,0,0,  0,  1, 32'h104, 6, 1,0,0, 1, 0);
    vecs[4]  = mk(1,0,0,0, 1, 32'h200, 7, 1,0,0,  0,  1, 32'h200, 7, 1,0,0, 1, 0);
    vecs[5]  = mk(1,0,1,1, 1, 32'h300, 8, 1,1,1,  1,  1, 32'h200, 7, 1,0,0, 1, 0);
    vecs[6]  = mk(1,0,1,1, 1, 32'h300, 8, 1,1,1,  1,  1, 32'h200, 7, 1,0,0, 1, 0);
    vecs[7]  = mk(1,0,1,1, 1, 32'h300, 8, 1,1,1,  1,  1, 32'h200, 7, 1,0,0, 1, 0);
    vecs[8]  = mk(1,1,1,1, 1, 32'h400, 9, 1,0,1,  0,  0, 32'h200, 7, 0,0,0, 1, 1);
    vecs[9]  = mk(1,0,0,0, 1, 32'h500, 0, 1,0,0,  0,  1, 32'h500, 0, 0,0,0, 1, 1);
    vecs[10] = mk(1,0,0,0, 0, 32'h600, 9, 1,1,1,  0,  0, 32'h600, 9, 0,0,0, 1, 1);
    vecs[11] = mk(1,0,0,0, 1, 32'h700, 3, 1,0,1,  0,  1, 32'h700, 3, 1,0,1, 1, 1);
    vecs[12] = mk(0,0,1,0, 1, 32'h780, 3, 1,0,0,  1,  0, 32'h0,   0, 0,0,0, 0, 0);
    vecs[13] = mk(1,0,0,0, 1, 32'h800, 4, 1,0,0,  0,  1, 32'h800, 4, 1,0,0, 0, 0);
    vecs[14] = mk(1,0,0,1, 1, 32'h804, 5, 1,0,0,  1,  0, 32'h800, 4, 0,0,0, 1, 0);
    vecs[15] = mk(1,0,0,1, 1, 32'h804, 5, 1,0,0,  1,  0, 32'h800, 4, 0,0,0, 2, 0);

    for (int i = 0; i < 16; i++) begin
      rst_n = vecs[i].rst_n; ex_flush = vecs[i].flush; ex_stall = vecs[i].stall;
      insert_nop = vecs[i].nop;
      id = '0;
      id.valid = vecs[i].valid; id.pc = vecs[i].pc; id.rd = vecs[i].rd;
      id.reg_write = vecs[i].rw; id.mem_read = vecs[i].mr; id.mem_write = vecs[i].mw;
      #1;
      chk("id_hold", i, {31'd0, id_hold}, {31'd0, vecs[i].exp_hold});
      @(posedge clk); #1;
      chk("de_valid", i, {31'd0, de.valid}, {31'd0, vecs[i].exp_valid});
      chk("de_pc", i, de.pc, vecs[i].exp_pc);
      chk("de_rd", i, {27'd0, de.rd}, {27'd0, vecs[i].exp_rd});
      chk("de_ctrl", i, {29'd0, de.reg_write, de.mem_read, de.mem_write},
          {29'd0, vecs[i].exp_rw, vecs[i].exp_mr, vecs[i].exp_mw});
`ifdef CORE_DE_PERF_EN
      chk("bubble_cnt", i, bubble_cnt, vecs[i].exp_bub);
      chk("flush_cnt", i, flush_cnt, vecs[i].exp_fl);
`endif
    end

    // Randomized run: resynchronise the model with a reset first.
    m_de = '0; m_bub = 0; m_fl = 0;
    for (int i = 0; i < 2000; i++) begin
      rst_n      = (i == 0) ? 1'b0 : ($urandom_range(0, 29) != 0);
      ex_flush   = ($urandom_range(0, 7) == 0);
      ex_stall   = ($urandom_range(0, 3) == 0);
      insert_nop = ($urandom_range(0, 3) == 0);
      rbits = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      id = rbits[153:0];
      if ($urandom_range(0, 4) == 0) id.rd = 5'd0;
      #1;
      chk("rand_id_hold", i, {31'd0, id_hold}, {31'd0, !ex_flush && (ex_stall || insert_nop)});
      model_step(rst_n, ex_flush, ex_stall, insert_nop, id);
      @(posedge clk); #1;
      chk_slot(i, de, m_de);
`ifdef CORE_DE_PERF_EN
      chk("rand_bubble_cnt", i, bubble_cnt, m_bub);
      chk("rand_flush_cnt", i, flush_cnt, m_fl);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_de_pipe_reg.md
CORE_DE_PIPE_REG -- requirements
Module: core_de_pipe_reg

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising edge of clk.
REQ-003 SHALL have inputs id_valid (1), id_pc (32), id_rs1_data (32), id_rs2_data (32), id_imm (32): decoded ID-stage instruction and operands.
REQ-004 SHALL have inputs id_rs1 (5), id_rs2 (5), id_rd (5), id_alu_op (4), id_funct3 (3): ID register indices and op fields.
REQ-005 SHALL have inputs id_reg_write (1), id_mem_read (1), id_mem_write (1): ID control bits.
REQ-006 SHALL have input insert_nop (1): load-use hazard request from the ID hazard detector.
REQ-007 SHALL have input ex_flush (1): taken branch/jump resolved in EX; kill ID and DE contents.
REQ-008 SHALL have input ex_stall (1): EX/MEM cannot accept; hold the DE register.
REQ-009 SHALL have outputs de_valid (1), de_pc (32), de_rs1_data (32), de_rs2_data (32), de_imm (32), de_rs1 (5), de_rs2 (5), de_rd (5), de_alu_op (4), de_funct3 (3), de_reg_write (1), de_mem_read (1), de_mem_write (1): registered DE-stage copy of every ID field.
REQ-010 SHALL have output id_hold (1), combinational: IF/ID and PC must not advance this cycle.
REQ-011 SHALL have outputs bubble_cnt (32), flush_cnt (32), present only under CORE_DE_PERF_EN.

Function
REQ-012 SHALL, per cycle, apply exactly one action by priority: flush > stall > bubble > load.
REQ-013 Flush (ex_flush=1): de_valid, de_reg_write, de_mem_read, de_mem_write SHALL become 0 next cycle; datapath fields hold previous value.
REQ-014 Stall (ex_flush=0, ex_stall=1): every de_* output SHALL hold its value, regardless of insert_nop.
REQ-015 Bubble (ex_flush=0, ex_stall=0, insert_nop=1): de_valid and de_reg_write/de_mem_read/de_mem_write SHALL become 0; datapath fields hold.
REQ-016 Load (none of the above): all de_* SHALL capture id_* next cycle; de_valid<=id_valid; control bits ANDed with id_valid.
REQ-017 On load, de_reg_write SHALL be forced 0 when id_rd==0 (x0 never a hazard source).
REQ-018 id_hold SHALL equal !ex_flush && (ex_stall || insert_nop); flush never holds IF/ID.
REQ-019 Latency id_* to de_* SHALL be exactly 1 cycle on load; no combinational path id_* to de_*.
REQ-020 Back-to-back insert_nop for N cycles SHALL produce N consecutive invalid DE slots with id_hold high N cycles.
REQ-021 insert_nop arriving while ex_stall=1 SHALL be ignored that cycle (re-evaluated by detector next cycle).

Reset
REQ-022 On rst_n=0 at a clk edge, all de_* outputs SHALL be 0 next cycle, overriding flush/stall/bubble/load.
REQ-023 Reset mid-stall SHALL discard the held instruction; first cycle after release with no hazard SHALL load.
REQ-024 id_hold SHALL be a pure function of inputs and unaffected by rst_n.

Configuration
REQ-025 Macro CORE_DE_PERF_EN SHALL gate performance counters.
REQ-026 With CORE_DE_PERF_EN: bubble_cnt increments by 1 on each bubble-action cycle; flush_cnt on each flush-action cycle; both reset to 0, wrap 0xFFFFFFFF->0, hold during stall.
REQ-027 Without CORE_DE_PERF_EN: bubble_cnt/flush_cnt ports and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Load: id_valid=1, id_pc=0x100, id_rd=5, id_reg_write=1, no hazards -> next cycle de_valid=1, de_pc=0x100, de_rd=5, de_reg_write=1; id_hold=0.
REQ-029 Load-use bubble: DE holds lw x5, ID add x6,x5,x1, insert_nop=1 one cycle -> id_hold=1 that cycle; next de_valid=0, de_mem_read=0; following cycle de_pc=add's pc; bubble_cnt=1.
REQ-030 Stall priority: ex_stall=1 and insert_nop=1 for 3 cycles with de_pc=0x200 -> de_pc=0x200, de_valid unchanged all 3 cycles, id_hold=1, bubble_cnt unchanged.
REQ-031 Flush priority: ex_flush=1, ex_stall=1, insert_nop=1 -> id_hold=0; next cycle de_valid=0, de_reg_write=0, de_mem_write=0; flush_cnt=1.
REQ-032 x0 and reset: load id_rd=0, id_reg_write=1 -> de_reg_write=0; then rst_n=0 one edge during ex_stall=1 -> all de_*=0, counters=0.
